rf_param: RTL

RF_PARAM -- requirements
Module: rf_param

---
 rtl/rf_param.sv | 99 +++++++++
 1 files changed

// File: rtl/rf_param.sv
// Parameterised register file with two registered read ports, one byte-enabled
// write port, optional hard-wired zero entry, and a one-entry-per-cycle clear sequencer.
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   raddra,
  input  logic [ADDR_W-1:0]   raddrb,
  input  logic                ren,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                wen,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic [DATA_W-1:0]   douta,
  output logic [DATA_W-1:0]   doutb
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rda, rdb;
  logic              idle;
  logic              wr_ok;

  assign idle     = (state == IDLE);
  assign clr_busy = (state == CLEAR);
  assign wr_ok    = idle && wen && !(ZERO_REG != 0 && waddr == '0);

  // Byte-merged value of the entry being written; used for both the write and bypass.
  always_comb begin
    merged = mem[waddr];
    for (int b = 0; b < NBYTES; b++) begin
      if (wbe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  always_comb begin
    rda = mem[raddra];
    rdb = mem[raddrb];
    if (BYPASS != 0 && wen && raddra == waddr) rda = merged;
    if (BYPASS != 0 && wen && raddrb == waddr) rdb = merged;
    if (ZERO_REG != 0 && raddra == '0) rda = '0;
    if (ZERO_REG != 0 && raddrb == '0) rdb = '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clr_req) state_nx = CLEAR;
      CLEAR:   if (idx == '1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // idx parks at 0 in IDLE so every clear sequence starts from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR && idx != '1) idx <= idx + 1'b1;
      else                             idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta <= '0;
      doutb <= '0;
    end else if (idle && ren) begin
      douta <= rda;
      doutb <= rdb;
    end
  end

endmodule
